// File: rtl/alu_issue_seq.sv
// alu_issue_seq: sequential issue/execute stage of the ALU datapath.
// Accepts one ADD/SUB/MUL command per handshake, runs it through a shared
// 8-bit carry-lookahead adder (MUL as a radix-2 Booth loop) and presents a
// sign-extended 16-bit result on a valid/ready output handshake.
module alu_issue_seq #(
    parameter int MUL_ITER = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_err,
    output logic        busy
);

    localparam int CW = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(MUL_ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    logic [1:0]    state;
    logic [1:0]    op_r;
    logic [7:0]    a_r;
    logic [7:0]    b_r;
    logic [16:0]   acc;
    logic [CW-1:0] count;

    logic [7:0]    cla_x;
    logic [7:0]    cla_y;
    logic          cla_cin;
    logic [8:0]    cla_out;
    logic          cla_bit8;
    logic [16:0]   acc_next;
    logic [15:0]   exec_result;

    // Four-bit lookahead block: all carries derived directly from g/p and ci.
    function automatic logic [3:0] carries4(input logic [3:0] g, input logic [3:0] p,
                                            input logic ci);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Eight-bit CLA built from two lookahead blocks; returns {carry_out, sum}.
    function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y,
                                        input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [3:0] lo;
        logic [3:0] hi;
        logic [8:0] c;
        g  = x & y;
        p  = x ^ y;
        lo = carries4(g[3:0], p[3:0], cin);
        hi = carries4(g[7:4], p[7:4], lo[3]);
        c  = {hi, lo, cin};
        return {c[8], p ^ c[7:0]};
    endfunction

    // Shared adder operand select: Booth step in MUL, otherwise A plus/minus B.
    always_comb begin
        cla_x   = a_r;
        cla_y   = b_r;
        cla_cin = 1'b0;
        if (state == S_MUL) begin
            cla_x = acc[16:9];
            cla_y = 8'h00;
            case (acc[1:0])
                2'b01:   cla_y = a_r;
                2'b10:   begin
                    cla_y   = ~a_r;
                    cla_cin = 1'b1;
                end
                default: cla_y = 8'h00;
            endcase
        end else if (op_r == OP_SUB) begin
            cla_y   = ~b_r;
            cla_cin = 1'b1;
        end
    end

    // The ninth sum bit comes from the sign rule so the add never overflows,
    // and the Booth shift simply drops that bit in on top of the accumulator.
    assign cla_out     = cla8(cla_x, cla_y, cla_cin);
    assign cla_bit8    = cla_out[8] ^ cla_x[7] ^ cla_y[7];
    assign acc_next    = {cla_bit8, cla_out[7:0], acc[8:1]};
    assign exec_result = {{8{cla_bit8}}, cla_out[7:0]};

    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // Command FSM: capture on accept, execute or iterate, then hold the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_r       <= OP_ADD;
            a_r        <= 8'h00;
            b_r        <= 8'h00;
            acc        <= 17'h0;
            count      <= '0;
            out_result <= 16'h0000;
            out_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r <= in_op;
                        a_r  <= in_a;
                        b_r  <= in_b;
                        if (in_op == OP_MUL) begin
                            count <= '0;
                            acc   <= {8'h00, in_b, 1'b0};
                            state <= S_MUL;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (op_r == OP_RSV) begin
                        out_result <= 16'h0000;
                        out_err    <= 1'b1;
                    end else begin
                        out_result <= exec_result;
                        out_err    <= 1'b0;
                    end
                    state <= S_DONE;
                end
                S_MUL: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (count == LAST_ITER) begin
                        out_result <= acc_next[16:1];
                        out_err    <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: scoreboard bench for the ALU issue/execute stage.
module tb_alu_issue_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];

    alu_issue_seq #(.MUL_ITER(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Behavioural reference using plain signed integer arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa;
        int   sbv;
        int   r;
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        case (op)
            2'b00:   r = sa + sbv;
            2'b01:   r = sa - sbv;
            2'b10:   r = sa * sbv;
            default: r = 0;
        endcase
        e.res = r[15:0];
        e.err = (op == 2'b11);
        return e;
    endfunction

    // Drive one command for a single cycle and record its expected result.
    task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input exp_t e);
        @(negedge clk);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
    endtask

    // Count edges until out_valid rises (bounded), noting whether busy stayed high.
    task automatic wait_out(output int cycles, output logic busy_all);
        cycles   = 0;
        busy_all = 1'b1;
        while (!out_valid && cycles < 20) begin
            if (!busy) busy_all = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got v=%b r=%h e=%b busy=%b expected 0/0000/0/0",
                     out_valid, out_result, out_err, busy);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b expected 0 while rst high", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        logic [7:0]  av [4] = '{8'h7F, 8'h80, 8'hFF, 8'h7F};
        logic [7:0]  bv [4] = '{8'h01, 8'h80, 8'hFF, 8'h7F};
        logic [15:0] rv [4] = '{16'h0080, 16'hFF00, 16'hFFFE, 16'h00FE};
        exp_t e;
        int   cyc;
        logic bz;
        for (int i = 0; i < 4; i++) begin
            issue(2'b00, av[i], bv[i], '{res: rv[i], err: 1'b0});
            wait_out(cyc, bz);
            e = sb.pop_front();
            checks++;
            if (cyc !== 1) begin
                errors++;
                $display("[TB] FAIL add_latency got %0d expected 1", cyc);
            end
            checks++;
            if (out_result !== e.res || out_err !== e.err) begin
                errors++;
                $display("[TB] FAIL add_result a=%h b=%h got %h/%b expected %h/%b",
                         av[i], bv[i], out_result, out_err, e.res, e.err);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_sub();
        logic [7:0]  av [4] = '{8'h80, 8'h05, 8'h7F, 8'h80};
        logic [7:0]  bv [4] = '{8'h01, 8'h05, 8'h80, 8'h7F};
        logic [15:0] rv [4] = '{16'hFF7F, 16'h0000, 16'h00FF, 16'hFF01};
        exp_t e;
        int   cyc;
        logic bz;
        for (int i = 0; i < 4; i++) begin
            issue(2'b01, av[i], bv[i], '{res: rv[i], err: 1'b0});
            wait_out(cyc, bz);
            e = sb.pop_front();
            checks++;
            if (cyc !== 1) begin
                errors++;
                $display("[TB] FAIL sub_latency got %0d expected 1", cyc);
            end
            checks++;
            if (out_result !== e.res || out_err !== e.err) begin
                errors++;
                $display("[TB] FAIL sub_result a=%h b=%h got %h/%b expected %h/%b",
                         av[i], bv[i], out_result, out_err, e.res, e.err);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_mul();
        logic [7:0]  av [5] = '{8'h80, 8'hFF, 8'h7F, 8'h7F, 8'h00};
        logic [7:0]  bv [5] = '{8'h80, 8'h05, 8'h80, 8'h7F, 8'h80};
        logic [15:0] rv [5] = '{16'h4000, 16'hFFFB, 16'hC080, 16'h3F01, 16'h0000};
        exp_t e;
        int   cyc;
        logic bz;
        for (int i = 0; i < 5; i++) begin
            issue(2'b10, av[i], bv[i], '{res: rv[i], err: 1'b0});
            wait_out(cyc, bz);
            e = sb.pop_front();
            checks++;
            if (cyc !== 8 || bz !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mul_latency got %0d busy_all=%b expected 8/1", cyc, bz);
            end
            checks++;
            if (out_result !== e.res || out_err !== e.err) begin
                errors++;
                $display("[TB] FAIL mul_result a=%h b=%h got %h/%b expected %h/%b",
                         av[i], bv[i], out_result, out_err, e.res, e.err);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reserved();
        exp_t e;
        int   cyc;
        logic bz;
        issue(2'b11, 8'h12, 8'h34, '{res: 16'h0000, err: 1'b1});
        wait_out(cyc, bz);
        e = sb.pop_front();
        checks++;
        if (cyc !== 1 || out_result !== e.res || out_err !== e.err) begin
            errors++;
            $display("[TB] FAIL reserved_op got lat=%0d %h/%b expected lat=1 %h/%b",
                     cyc, out_result, out_err, e.res, e.err);
        end
        @(posedge clk);
        #1;
        issue(2'b00, 8'h01, 8'h01, '{res: 16'h0002, err: 1'b0});
        wait_out(cyc, bz);
        e = sb.pop_front();
        checks++;
        if (cyc !== 1 || out_result !== e.res || out_err !== e.err) begin
            errors++;
            $display("[TB] FAIL add_after_reserved got lat=%0d %h/%b expected lat=1 %h/%b",
                     cyc, out_result, out_err, e.res, e.err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        exp_t        e;
        int          cyc;
        logic        bz;
        logic [15:0] held;
        out_ready = 1'b0;
        issue(2'b10, 8'h13, 8'hF6, '{res: 16'hFF42, err: 1'b0});
        wait_out(cyc, bz);
        e = sb.pop_front();
        checks++;
        if (cyc !== 8 || out_result !== e.res || out_err !== e.err) begin
            errors++;
            $display("[TB] FAIL bp_result got lat=%0d %h/%b expected lat=8 %h/%b",
                     cyc, out_result, out_err, e.res, e.err);
        end
        held = e.res;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            in_op    = 2'($urandom);
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_result !== held || out_err !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle=%0d got v=%b r=%h e=%b rdy=%b expected 1/%h/0/0",
                         i, out_valid, out_result, out_err, in_ready, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_result !== held) begin
            errors++;
            $display("[TB] FAIL bp_release got v=%b rdy=%b busy=%b r=%h expected 0/1/0/%h",
                     out_valid, in_ready, busy, out_result, held);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_no_stray_cmd got v=%b busy=%b expected 0/0", out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_mul();
        exp_t e;
        int   cyc;
        logic bz;
        issue(2'b10, 8'h7F, 8'h7F, '{res: 16'h3F01, err: 1'b0});
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_mul_reset got v=%b r=%h e=%b busy=%b expected 0/0000/0/0",
                     out_valid, out_result, out_err, busy);
        end
        rst = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_mul_in_ready got %b expected 1", in_ready);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_mul_aborted got v=%b busy=%b expected 0/0", out_valid, busy);
        end
        issue(2'b00, 8'h03, 8'h04, '{res: 16'h0007, err: 1'b0});
        wait_out(cyc, bz);
        e = sb.pop_front();
        checks++;
        if (cyc !== 1 || out_result !== e.res || out_err !== e.err) begin
            errors++;
            $display("[TB] FAIL add_after_reset got lat=%0d %h/%b expected lat=1 %h/%b",
                     cyc, out_result, out_err, e.res, e.err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        int         cyc;
        int         lat;
        logic       bz;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready idx=%0d got %b expected 1", i, in_ready);
            end
            issue(op, a, b, model(op, a, b));
            lat = (op == 2'b10) ? 8 : 1;
            wait_out(cyc, bz);
            e = sb.pop_front();
            checks++;
            if (cyc !== lat || out_result !== e.res || out_err !== e.err) begin
                errors++;
                $display("[TB] FAIL b2b_result op=%0d a=%h b=%h got lat=%0d %h/%b expected lat=%0d %h/%b",
                         op, a, b, cyc, out_result, out_err, lat, e.res, e.err);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Hard stop in case something above never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    // Scenario sequence.
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_reserved();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
